// File: rtl/auth_pkg.sv
// Shared types and defaults for the challenge-response controller.
// Holds the FSM state encoding, the default key and the response window.
package auth_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CAPTURE = 3'd1,
      SEND_HI = 3'd2,
      SEND_LO = 3'd3,
      WAIT_HI = 3'd4,
      WAIT_LO = 3'd5,
      RESULT  = 3'd6
   } state_e;

   localparam logic [15:0] DEF_KEY       = 16'h5A3C;
   localparam int          DEF_TIMEOUT   = 12_000_000;
   localparam int          DEF_MAX_FAILS = 3;

endpackage

// File: rtl/auth_timer.sv
// Response-window timer: clearable up-counter, expiry flag on the
// last cycle of the window.
module auth_timer
   import auth_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + W'(1);
      end
   end

   assign expired = en && (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/challenge_auth.sv
// Challenge-response controller between the LFSR and the UART link.
// Optional consecutive-failure lockout is enabled by AUTH_LOCKOUT_EN.
module challenge_auth
   import auth_pkg::*;
#(
   parameter logic [15:0] KEY            = DEF_KEY,
   parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT,
   parameter int          MAX_FAILS      = DEF_MAX_FAILS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] lfsr_random,
   output logic        lfsr_enable,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        busy,
   output logic        pass,
   output logic        fail,
   output logic        authenticated,
   output logic        locked
);

   state_e      state;
   state_e      nxt;
   logic [15:0] chal;
   logic [15:0] resp;
   logic        err;
   logic        ok;
   logic        go;
   logic        waiting;
   logic        expired;

   assign resp    = chal ^ KEY;
   assign waiting = (state == WAIT_HI) || (state == WAIT_LO);
   assign go      = (state == IDLE) && start && !locked;

   auth_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (!waiting),
      .en     (waiting),
      .expired(expired)
   );

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (go) nxt = CAPTURE;
         CAPTURE: nxt = SEND_HI;
         SEND_HI: if (tx_ready) nxt = SEND_LO;
         SEND_LO: if (tx_ready) nxt = WAIT_HI;
         WAIT_HI: begin
            if (expired)       nxt = RESULT;
            else if (rx_valid) nxt = WAIT_LO;
         end
         WAIT_LO: begin
            if (expired || rx_valid) nxt = RESULT;
         end
         RESULT:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         chal          <= '0;
         err           <= 1'b0;
         ok            <= 1'b0;
         authenticated <= 1'b0;
      end else begin
         state <= nxt;
         if (state == CAPTURE) begin
            chal <= lfsr_random;
            err  <= 1'b0;
         end
         if (state == WAIT_HI) begin
            ok <= 1'b0;
            if (rx_valid && !expired) err <= (rx_data != resp[15:8]);
         end
         // verdict is latched every WAIT_LO cycle; the last one is kept
         if (state == WAIT_LO) begin
            ok <= !expired && rx_valid && !err && (rx_data == resp[7:0]);
         end
         if (go) authenticated <= 1'b0;
         if (state == RESULT) authenticated <= ok;
      end
   end

   assign lfsr_enable = go && rst_n;
   assign tx_valid    = (state == SEND_HI) || (state == SEND_LO);
   assign tx_data     = (state == SEND_HI) ? chal[15:8] :
                        (state == SEND_LO) ? chal[7:0]  : 8'h00;
   assign busy        = (state != IDLE);
   assign pass        = (state == RESULT) && ok;
   assign fail        = (state == RESULT) && !ok;

`ifdef AUTH_LOCKOUT_EN
   localparam int FW = $clog2(MAX_FAILS + 1);

   logic [FW-1:0] fails;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fails <= '0;
      end else if (pass) begin
         fails <= '0;
      end else if (fail && (fails != FW'(MAX_FAILS))) begin
         fails <= fails + FW'(1);
      end
   end

   assign locked = (fails == FW'(MAX_FAILS));
`else
   logic unused_max_fails;

   assign unused_max_fails = (MAX_FAILS > 0);
   assign locked           = 1'b0;
`endif

endmodule

// File: tb/tb_challenge_auth.sv
// Randomized self-checking bench for challenge_auth.
// Reference model: response = challenge ^ KEY, window of T cycles.
module tb_challenge_auth;

   localparam int          T   = 100;
   localparam logic [15:0] KEY = 16'h5A3C;
`ifdef AUTH_LOCKOUT_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] lfsr_random;
   logic        lfsr_enable;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        busy;
   logic        pass;
   logic        fail;
   logic        authenticated;
   logic        locked;

   int checks   = 0;
   int failures = 0;
   bit m_auth;
   int m_fails;

   always #5 clk = ~clk;

   challenge_auth #(
      .KEY           (KEY),
      .TIMEOUT_CYCLES(T),
      .MAX_FAILS     (3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .lfsr_random  (lfsr_random),
      .lfsr_enable  (lfsr_enable),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .busy         (busy),
      .pass         (pass),
      .fail         (fail),
      .authenticated(authenticated),
      .locked       (locked)
   );

   function automatic bit m_locked();
      return LOCK && (m_fails >= 3);
   endfunction

   task automatic test_reset();
      rst_n       = 1'b0;
      start       = 1'b0;
      tx_ready    = 1'b0;
      rx_valid    = 1'b0;
      rx_data     = 8'h00;
      lfsr_random = 16'h0000;
      repeat (3) @(negedge clk);
      checks++;
      if ({lfsr_enable, tx_valid, tx_data, busy, pass, fail,
           authenticated, locked} !== 15'b0)
         begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0",
                     {lfsr_enable, tx_valid, tx_data, busy, pass, fail,
                      authenticated, locked});
         end
      rst_n = 1'b1;
      @(negedge clk);
      m_auth  = 1'b0;
      m_fails = 0;
      checks++;
      if (busy !== 1'b0 || locked !== 1'b0) begin
         failures++;
         $display("FAIL reset_release busy=%b locked=%b want 0 0",
                  busy, locked);
      end
   endtask

   // Start an exchange from IDLE and drive it through both TX bytes.
   task automatic begin_exchange(input logic [15:0] pre,
                                 input logic [15:0] chal,
                                 input int st_hi, input int st_lo,
                                 input bit noise);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_busy got=%b want=0", busy);
      end
      lfsr_random = pre;
      start       = 1'b1;
      #1;
      checks++;
      if (lfsr_enable !== 1'b1) begin
         failures++;
         $display("FAIL start_enable got=%b want=1", lfsr_enable);
      end
      @(negedge clk);
      start       = noise ? 1'($urandom) : 1'b0;
      lfsr_random = chal;
      m_auth      = 1'b0;
      checks++;
      if (lfsr_enable !== 1'b0 || busy !== 1'b1 || tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL capture en=%b busy=%b txv=%b want 0 1 0",
                  lfsr_enable, busy, tx_valid);
      end
      @(negedge clk);
      for (int b = 0; b < 2; b++) begin
         int          st;
         logic [7:0]  want;
         st   = (b == 0) ? st_hi : st_lo;
         want = (b == 0) ? chal[15:8] : chal[7:0];
         for (int i = 0; i <= st; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== want ||
                lfsr_enable !== 1'b0) begin
               failures++;
               $display("FAIL send_b%0d_c%0d txv=%b data=%h en=%b want 1 %h 0",
                        b, i, tx_valid, tx_data, lfsr_enable, want);
            end
            tx_ready = (i == st);
            if (noise) begin
               start    = 1'($urandom);
               rx_valid = 1'($urandom);
               rx_data  = 8'($urandom);
            end
            @(negedge clk);
         end
      end
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      start    = 1'b0;
   endtask

   // Drive response bytes at wait-cycle k0/k1 (-1 = never) and check verdict.
   task automatic respond(input logic [15:0] chal,
                          input logic [7:0] r_hi, input logic [7:0] r_lo,
                          input int k0, input int k1, input bit noise);
      logic [15:0] want;
      bit          hi_ok;
      bit          lo_ok;
      bit          e_pass;
      int          e_cyc;
      want   = chal ^ KEY;
      hi_ok  = (k0 >= 0) && (k0 < T - 1);
      lo_ok  = hi_ok && (k1 > k0) && (k1 < T - 1);
      e_cyc  = lo_ok ? k1 + 1 : T;
      e_pass = lo_ok && (r_hi == want[15:8]) && (r_lo == want[7:0]);
      for (int k = 0; k <= e_cyc; k++) begin
         checks++;
         if (pass !== (k == e_cyc && e_pass) ||
             fail !== (k == e_cyc && !e_pass) ||
             busy !== 1'b1 || lfsr_enable !== 1'b0) begin
            failures++;
            $display("FAIL wait_k%0d pass=%b fail=%b busy=%b en=%b want %b %b 1 0",
                     k, pass, fail, busy, lfsr_enable,
                     (k == e_cyc && e_pass), (k == e_cyc && !e_pass));
         end
         rx_valid = (k == k0) || (k == k1);
         rx_data  = (k == k0) ? r_hi : (k == k1) ? r_lo : 8'($urandom);
         start    = (noise && k < e_cyc) ? 1'($urandom) : 1'b0;
         @(negedge clk);
      end
      rx_valid = 1'b0;
      start    = 1'b0;
      if (e_pass) begin
         m_auth  = 1'b1;
         m_fails = 0;
      end else begin
         m_auth  = 1'b0;
         m_fails = (m_fails < 3) ? m_fails + 1 : 3;
      end
      checks++;
      if (busy !== 1'b0 || authenticated !== m_auth ||
          locked !== m_locked()) begin
         failures++;
         $display("FAIL after busy=%b auth=%b locked=%b want 0 %b %b",
                  busy, authenticated, locked, m_auth, m_locked());
      end
   endtask

   task automatic test_basic();
      begin_exchange(16'hACE1, 16'h59C3, 0, 0, 1'b0);
      respond(16'h59C3, 8'h03, 8'hFF, 2, 4, 1'b0);
   endtask

   task automatic test_stall();
      begin_exchange(16'h1234, 16'h59C3, 5, 0, 1'b0);
      respond(16'h59C3, 8'h03, 8'h00, 0, 1, 1'b0);
   endtask

   task automatic test_timeout();
      begin_exchange(16'hBEEF, 16'h59C3, 0, 1, 1'b0);
      respond(16'h59C3, 8'h03, 8'hFF, -1, -1, 1'b0);
   endtask

   task automatic test_idle_rx();
      for (int i = 0; i < 4; i++) begin
         rx_valid = 1'b1;
         rx_data  = (i == 0) ? 8'h03 : 8'hFF;
         @(negedge clk);
         checks++;
         if (pass !== 1'b0 || fail !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_rx_%0d pass=%b fail=%b busy=%b want 0 0 0",
                     i, pass, fail, busy);
         end
      end
      rx_valid = 1'b0;
      begin_exchange(16'h0F0F, 16'h59C3, 0, 0, 1'b0);
      respond(16'h59C3, 8'h03, 8'hFF, 1, 2, 1'b0);
   endtask

   task automatic test_back_to_back_noise();
      begin_exchange(16'h7777, 16'hC0DE, 2, 1, 1'b1);
      respond(16'hC0DE, 8'h9A, 8'hE2, 0, 3, 1'b1);
      begin_exchange(16'hC0DE, 16'h8421, 0, 3, 1'b1);
      respond(16'h8421, 8'hDE, 8'h1D, 4, 5, 1'b1);
   endtask

   task automatic test_coincident();
      begin_exchange(16'h1111, 16'h59C3, 0, 0, 1'b0);
      respond(16'h59C3, 8'h03, 8'hFF, 3, T - 1, 1'b0);
      begin_exchange(16'h2222, 16'h59C3, 0, 0, 1'b0);
      respond(16'h59C3, 8'h03, 8'hFF, T - 1, T, 1'b0);
   endtask

   task automatic test_reset_mid();
      begin_exchange(16'h3333, 16'h59C3, 0, 0, 1'b0);
      rx_valid = 1'b1;
      rx_data  = 8'h03;
      @(negedge clk);
      rx_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || pass !== 1'b0 || fail !== 1'b0) begin
         failures++;
         $display("FAIL mid_wait_lo busy=%b pass=%b fail=%b want 1 0 0",
                  busy, pass, fail);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({lfsr_enable, tx_valid, tx_data, busy, pass, fail,
           authenticated, locked} !== 15'b0) begin
         failures++;
         $display("FAIL mid_reset got=%b want=0",
                  {lfsr_enable, tx_valid, tx_data, busy, pass, fail,
                   authenticated, locked});
      end
      @(negedge clk);
      rst_n   = 1'b1;
      m_auth  = 1'b0;
      m_fails = 0;
      @(negedge clk);
      begin_exchange(16'h4444, 16'h59C3, 0, 0, 1'b0);
      respond(16'h59C3, 8'h03, 8'hFF, 0, 1, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 20; n++) begin
         logic [15:0] c;
         logic [15:0] w;
         logic [7:0]  rh;
         logic [7:0]  rl;
         int          k0;
         int          k1;
         bit          nz;
         if (m_locked()) test_reset();
         c  = 16'($urandom);
         w  = c ^ KEY;
         rh = ($urandom_range(3, 0) != 0) ? w[15:8] : 8'($urandom);
         rl = ($urandom_range(3, 0) != 0) ? w[7:0]  : 8'($urandom);
         k0 = $urandom_range(6, 0);
         k1 = k0 + 1 + $urandom_range(6, 0);
         if ($urandom_range(7, 0) == 0) begin
            k0 = T - 4 + $urandom_range(3, 0);
            k1 = k0 + 1 + $urandom_range(2, 0);
         end
         nz = 1'($urandom);
         begin_exchange(16'($urandom), c, $urandom_range(3, 0),
                        $urandom_range(3, 0), nz);
         respond(c, rh, rl, k0, k1, nz);
      end
   endtask

   task automatic test_lockout();
      test_reset();
      for (int i = 0; i < 3; i++) begin
         begin_exchange(16'h5555, 16'h1357, 0, 0, 1'b0);
         respond(16'h1357, 8'h00, 8'h00, -1, -1, 1'b0);
      end
      checks++;
      if (locked !== m_locked()) begin
         failures++;
         $display("FAIL lock_level got=%b want=%b", locked, m_locked());
      end
      start = 1'b1;
      #1;
      checks++;
      if (lfsr_enable !== !m_locked()) begin
         failures++;
         $display("FAIL lock_start en=%b want=%b", lfsr_enable, !m_locked());
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== !m_locked()) begin
         failures++;
         $display("FAIL lock_busy got=%b want=%b", busy, !m_locked());
      end
      test_reset();
      for (int i = 0; i < 2; i++) begin
         begin_exchange(16'h6666, 16'h2468, 0, 0, 1'b0);
         respond(16'h2468, 8'h00, 8'h00, 0, 1, 1'b0);
      end
      begin_exchange(16'h6666, 16'h2468, 0, 0, 1'b0);
      respond(16'h2468, 8'h7E, 8'h54, 0, 1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         begin_exchange(16'h6666, 16'h2468, 0, 0, 1'b0);
         respond(16'h2468, 8'h7E, 8'h00, 0, 1, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_timeout();
      test_idle_rx();
      test_back_to_back_noise();
      test_coincident();
      test_reset_mid();
      test_random();
      test_lockout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
